// File: rtl/mix_cols_iter.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional feature macro: MIXCOLS_BYPASS_EN adds in_bypass for a pass-through (final round) block.
module mix_cols_iter #(
    parameter int unsigned NB             = 4,
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
`ifdef MIXCOLS_BYPASS_EN
    input  logic             in_bypass,
`endif
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data
);

    localparam int unsigned CntW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned LastCnt = NB - COLS_PER_CYCLE;

    if (COLS_PER_CYCLE == 0 || NB % COLS_PER_CYCLE != 0) begin : gBadParams
        $error("mix_cols_iter: COLS_PER_CYCLE must divide NB exactly");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

    stateT             state;
    logic [32*NB-1:0]  dataQ;
    logic [32*NB-1:0]  nextData;
    logic              invQ;
    logic [CntW-1:0]   colCnt;
    logic              lastStep;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Row 0 sits in the top byte; output row i uses inputs rotated by i (circulant matrix).
    function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] r  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (!inv) begin
                r[i] = m2[i] ^ (m2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
            end else begin
                r[i] = (m8[i] ^ m4[i] ^ m2[i])
                     ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    always_comb begin
        nextData = dataQ;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            nextData[32*(int'(colCnt)+k) +: 32] = mixColumn(dataQ[32*(int'(colCnt)+k) +: 32], invQ);
        end
    end

    assign lastStep = (colCnt == CntW'(LastCnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            dataQ     <= '0;
            invQ      <= 1'b0;
            colCnt    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        dataQ    <= in_data;
                        invQ     <= in_inv;
                        colCnt   <= '0;
                        in_ready <= 1'b0;
`ifdef MIXCOLS_BYPASS_EN
                        if (in_bypass) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            state <= StBusy;
                        end
`else
                        state <= StBusy;
`endif
                    end
                end
                StBusy: begin
                    dataQ <= nextData;
                    if (lastStep) begin
                        // out_data is a separate register so it holds the previous result while busy
                        out_data  <= nextData;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        colCnt <= colCnt + CntW'(COLS_PER_CYCLE);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
